text_pixel_renderer: RTL and testbench

- Consumes the raster timing produced by the VGA sync generator: pixel X/Y counters, display-area flag, and active-low H/V sync.
- Generates the per-pixel RGB332 colour for an 80x30 character text screen using 8x16 glyphs.
- Reads the editor's character buffer RAM and the font ROM through synchronous read ports, renders a blinking cursor, and re-aligns the syncs to the pixel pipeline.
- Its outputs drive the VGA connector pins directly.

---
 rtl/text_pkg.sv | 44 ++++
 rtl/text_pixel_renderer_if.sv | 34 +++
 rtl/cursor_blink_timer.sv | 41 ++++
 rtl/text_pixel_renderer.sv | 107 ++++++++++
 tb/tb_text_pixel_renderer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared constants, pipeline payload type and address helper for the text pixel renderer.
package text_pkg;

    localparam int unsigned TEXT_COLS   = 80;
    localparam int unsigned TEXT_ROWS   = 30;
    localparam int unsigned GLYPH_W     = 8;
    localparam int unsigned GLYPH_H     = 16;
    localparam int unsigned CHAR_ADDR_W = 12;
    localparam int unsigned FONT_ADDR_W = 11;
    localparam int unsigned PIPE_LAT    = 3;

    localparam int unsigned PIX_CNT_W   = 10;
    localparam int unsigned COL_W       = 7;
    localparam int unsigned ROW_W       = 5;
    localparam int unsigned GX_W        = $clog2(GLYPH_W);
    localparam int unsigned GY_W        = $clog2(GLYPH_H);
    localparam int unsigned RGB_W       = 8;
    localparam int unsigned CODE_W      = 7;
    localparam int unsigned DATA_W      = 8;

    localparam logic [RGB_W-1:0] RGB_BLACK = 8'h00;
    localparam logic [RGB_W-1:0] RGB_WHITE = 8'hFF;
    localparam logic [RGB_W-1:0] RGB_BLUE  = 8'h03;

    // Per-pixel control state carried alongside the memory lookups.
    typedef struct packed {
        logic [GX_W-1:0] x;
        logic [GY_W-1:0] y;
        logic            disp;
        logic            hit;
        logic            hs;
        logic            vs;
    } pix_ctl_t;

    // Flushed pipeline slot: blank pixel with both syncs inactive (high).
    localparam pix_ctl_t PIX_CTL_RST = '{x: '0, y: '0, disp: 1'b0, hit: 1'b0, hs: 1'b1, vs: 1'b1};

    // row*80 + col built from shifts; the largest cell index (2399) fits in 12 bits.
    function automatic logic [CHAR_ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                          input logic [COL_W-1:0] col);
        return (CHAR_ADDR_W'(row) << 6) + (CHAR_ADDR_W'(row) << 4) + CHAR_ADDR_W'(col);
    endfunction

endpackage

// File: rtl/text_pixel_renderer_if.sv
// Raster timing, cursor, memory read ports and VGA pin outputs of the text renderer.
interface text_pixel_renderer_if;
    import text_pkg::*;

    logic [PIX_CNT_W-1:0]   pixel_x;
    logic [PIX_CNT_W-1:0]   pixel_y;
    logic                   in_display;
    logic                   h_sync_in;
    logic                   v_sync_in;
    logic [COL_W-1:0]       cursor_col;
    logic [ROW_W-1:0]       cursor_row;
    logic [CHAR_ADDR_W-1:0] char_addr;
    logic [DATA_W-1:0]      char_data;
    logic [FONT_ADDR_W-1:0] font_addr;
    logic [DATA_W-1:0]      font_data;
    logic [RGB_W-1:0]       rgb;
    logic                   h_sync_out;
    logic                   v_sync_out;

    // Environment side: sync generator, editor state and memories.
    modport master (
        output pixel_x, pixel_y, in_display, h_sync_in, v_sync_in,
        output cursor_col, cursor_row, char_data, font_data,
        input  char_addr, font_addr, rgb, h_sync_out, v_sync_out
    );

    // Renderer side.
    modport slave (
        input  pixel_x, pixel_y, in_display, h_sync_in, v_sync_in,
        input  cursor_col, cursor_row, char_data, font_data,
        output char_addr, font_addr, rgb, h_sync_out, v_sync_out
    );

endinterface

// File: rtl/cursor_blink_timer.sv
// Cursor blink phase: toggles every BLINK_FRAMES falling edges of the vertical sync.
module cursor_blink_timer #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic v_sync_in,
    output logic blink_on
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             r_vs_prev;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_blink_on;
    logic             w_frame_tick;

    assign w_frame_tick = r_vs_prev & ~v_sync_in;
    assign blink_on     = r_blink_on;

    // Frame tick detection and frame counter with blink toggle on wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_prev   <= 1'b1;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_vs_prev <= v_sync_in;
            if (w_frame_tick) begin
                if (r_frame_cnt == CNT_LAST) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/text_pixel_renderer.sv
// 80x30 text-mode pixel renderer: char RAM -> font ROM -> RGB332, with blinking cursor.
// Three register stages; char_data and font_data are expected one cycle after the
// address registers, so rgb and the syncs trail the raster inputs by 3 cycles.
// Build option CURSOR_UNDERLINE_EN: underline cursor on glyph lines 14-15 instead of
// an inverted block.
module text_pixel_renderer
    import text_pkg::*;
#(
    parameter logic [RGB_W-1:0] FG_COLOR     = RGB_WHITE,
    parameter logic [RGB_W-1:0] BG_COLOR     = RGB_BLUE,
    parameter int unsigned      BLINK_FRAMES = 30
) (
    input logic                  clk,
    input logic                  reset,
    text_pixel_renderer_if.slave bus
);

    logic [COL_W-1:0]       w_col;
    logic [ROW_W-1:0]       w_row;
    logic                   w_hit;
    logic                   w_unused;
    logic                   w_blink_on;
    logic                   w_pix;
    logic                   w_cursor;
    logic                   w_on;

    logic [CHAR_ADDR_W-1:0] r_char_addr;
    pix_ctl_t               r_s0;
    logic [FONT_ADDR_W-1:0] r_font_addr;
    logic                   r_inverse;
    pix_ctl_t               r_s1;
    logic [RGB_W-1:0]       r_rgb;
    logic                   r_h_sync_out;
    logic                   r_v_sync_out;

    assign w_col    = bus.pixel_x[9:3];
    assign w_row    = bus.pixel_y[8:4];
    assign w_hit    = (w_col == bus.cursor_col) && (w_row == bus.cursor_row);
    assign w_unused = bus.pixel_y[9];

    cursor_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk      (clk),
        .reset    (reset),
        .v_sync_in(bus.v_sync_in),
        .blink_on (w_blink_on)
    );

    // Stage 0: character cell address and per-pixel control capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_char_addr <= '0;
            r_s0        <= PIX_CTL_RST;
        end else begin
            r_char_addr <= bus.in_display ? cell_addr(w_row, w_col) : '0;
            r_s0        <= '{x:    bus.pixel_x[GX_W-1:0],
                             y:    bus.pixel_y[GY_W-1:0],
                             disp: bus.in_display,
                             hit:  w_hit,
                             hs:   bus.h_sync_in,
                             vs:   bus.v_sync_in};
        end
    end

    // Stage 1: glyph line address from the character code; latch the inverse attribute.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_font_addr <= '0;
            r_inverse   <= 1'b0;
            r_s1        <= PIX_CTL_RST;
        end else begin
            r_font_addr <= {bus.char_data[CODE_W-1:0], r_s0.y};
            r_inverse   <= bus.char_data[DATA_W-1];
            r_s1        <= r_s0;
        end
    end

    assign w_pix    = bus.font_data[3'd7 - r_s1.x];
    assign w_cursor = r_s1.hit & w_blink_on;

`ifdef CURSOR_UNDERLINE_EN
    assign w_on = (w_cursor && (r_s1.y >= 4'd14)) ? 1'b1 : (w_pix ^ r_inverse);
`else
    assign w_on = w_pix ^ r_inverse ^ w_cursor;
`endif

    // Stage 2: final colour and re-aligned syncs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb        <= RGB_BLACK;
            r_h_sync_out <= 1'b1;
            r_v_sync_out <= 1'b1;
        end else begin
            r_rgb        <= r_s1.disp ? (w_on ? FG_COLOR : BG_COLOR) : RGB_BLACK;
            r_h_sync_out <= r_s1.hs;
            r_v_sync_out <= r_s1.vs;
        end
    end

    assign bus.char_addr  = r_char_addr;
    assign bus.font_addr  = r_font_addr;
    assign bus.rgb        = r_rgb;
    assign bus.h_sync_out = r_h_sync_out;
    assign bus.v_sync_out = r_v_sync_out;

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Scoreboard bench for text_pixel_renderer: random raster pixels against a screen model.
module tb_text_pixel_renderer;
    import text_pkg::*;

    localparam int unsigned BF        = 2;
    localparam logic [7:0]  FG        = 8'hFF;
    localparam logic [7:0]  BG        = 8'h03;
    localparam int          MAX_EDGES = 4096;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       disp;
        logic       hs;
        logic       vs;
        logic [6:0] cc;
        logic [4:0] cr;
    } stim_t;

    typedef struct {
        int          edge_n;
        logic [7:0]  rgb;
        logic        hs;
        logic        vs;
        logic [11:0] ca;
        logic [10:0] fa;
        bit          chk_fa;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    text_pixel_renderer_if bus ();

    text_pixel_renderer #(
        .FG_COLOR    (FG),
        .BG_COLOR    (BG),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [4096];
    logic [7:0] rom [2048];

    // Memories answer in the cycle after the renderer registers the address.
    assign bus.char_data = ram[bus.char_addr];
    assign bus.font_data = rom[bus.font_addr];

    logic  rst_a   [MAX_EDGES];
    stim_t stim_a  [MAX_EDGES];
    int    ticks_a [MAX_EDGES];
    int    edge_cnt = 0;
    int    ticks    = 0;
    int    checks   = 0;
    int    errors   = 0;
    exp_t  q [$];
    exp_t  mon_e;

    function automatic bit rst_at(input int k);
        return (k < 1) ? 1'b1 : rst_a[k];
    endfunction

    function automatic int cell_of(input stim_t s);
        return int'(s.y[8:4]) * int'(TEXT_COLS) + int'(s.x[9:3]);
    endfunction

    function automatic stim_t mk(input int x, input int y, input bit disp, input bit hs,
                                 input bit vs, input int cc, input int cr);
        stim_t s;
        s.x = 10'(x); s.y = 10'(y); s.disp = disp; s.hs = hs; s.vs = vs;
        s.cc = 7'(cc); s.cr = 5'(cr);
        return s;
    endfunction

    // Screen-level expectation for what the pins show after edge m.
    function automatic exp_t expect_at(input int m);
        exp_t       e;
        stim_t      p;
        int         src;
        int         ca_prev;
        logic [7:0] code;
        logic [7:0] line;
        logic       pix;
        logic       blink;
        logic       cur;
        logic       on;
        src      = m - int'(PIPE_LAT) + 1;
        e.edge_n = m;
        e.ca     = (rst_at(m) || !stim_a[m].disp) ? 12'd0 : 12'(cell_of(stim_a[m]));
        if (rst_at(m)) begin
            e.fa = 11'd0; e.chk_fa = 1'b1;
        end else if (rst_at(m - 1)) begin
            e.fa = 11'd0; e.chk_fa = 1'b0;
        end else begin
            ca_prev  = stim_a[m-1].disp ? cell_of(stim_a[m-1]) : 0;
            code     = ram[ca_prev];
            e.fa     = {code[6:0], stim_a[m-1].y[3:0]};
            e.chk_fa = 1'b1;
        end
        if (rst_at(m) || rst_at(m - 1) || rst_at(src)) begin
            e.rgb = 8'h00; e.hs = 1'b1; e.vs = 1'b1;
        end else begin
            p     = stim_a[src];
            e.hs  = p.hs;
            e.vs  = p.vs;
            blink = ((ticks_a[m-1] / int'(BF)) % 2) == 0;
            cur   = (p.cc == p.x[9:3]) && (p.cr == p.y[8:4]) && blink;
            code  = ram[cell_of(p)];
            line  = rom[{code[6:0], p.y[3:0]}];
            pix   = line[3'd7 - p.x[2:0]];
`ifdef CURSOR_UNDERLINE_EN
            on    = (cur && p.y[3:0] >= 4'd14) ? 1'b1 : (pix ^ code[7]);
`else
            on    = pix ^ code[7] ^ cur;
`endif
            e.rgb = !p.disp ? 8'h00 : (on ? FG : BG);
        end
        return e;
    endfunction

    // Drive one pixel, record it at its sampling edge and queue the expected pins.
    task automatic step(input logic rst, input stim_t s);
        reset          = rst;
        bus.pixel_x    = s.x;
        bus.pixel_y    = s.y;
        bus.in_display = s.disp;
        bus.h_sync_in  = s.hs;
        bus.v_sync_in  = s.vs;
        bus.cursor_col = s.cc;
        bus.cursor_row = s.cr;
        @(posedge clk);
        edge_cnt         = edge_cnt + 1;
        rst_a[edge_cnt]  = rst;
        stim_a[edge_cnt] = s;
        if (rst)
            ticks = 0;
        else if ((rst_at(edge_cnt - 1) ? 1'b1 : stim_a[edge_cnt-1].vs) && !s.vs)
            ticks = ticks + 1;
        ticks_a[edge_cnt] = ticks;
        q.push_back(expect_at(edge_cnt));
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks = checks + 1;
        if (act !== want) begin
            errors = errors + 1;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_cnt, act, want);
        end
    endtask

    // Monitor: compare the pins against the queued expectation for this edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].edge_n < edge_cnt) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL stale_entry: edge %0d never compared (now %0d)", q[0].edge_n, edge_cnt);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].edge_n == edge_cnt) begin
            mon_e = q.pop_front();
            chk("rgb",        32'(bus.rgb),        32'(mon_e.rgb));
            chk("h_sync_out", 32'(bus.h_sync_out), 32'(mon_e.hs));
            chk("v_sync_out", 32'(bus.v_sync_out), 32'(mon_e.vs));
            chk("char_addr",  32'(bus.char_addr),  32'(mon_e.ca));
            if (mon_e.chk_fa)
                chk("font_addr", 32'(bus.font_addr), 32'(mon_e.fa));
        end
    end

    initial begin
        stim_t s;
        logic  vs_lvl;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        ram[162] = 8'h41;
        ram[163] = 8'hC1;
        rom[11'h413] = 8'b0010_0000;
        ram[165] = 8'h00;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;

        repeat (4) step(1'b1, mk(0, 0, 0, 1, 1, 127, 31));

        // Directed glyph pixels in cell (2,2) and (3,2).
        step(1'b0, mk(17, 35, 1, 0, 1, 127, 31));
        step(1'b0, mk(18, 35, 1, 1, 1, 127, 31));
        step(1'b0, mk(19, 35, 1, 0, 1, 127, 31));
        step(1'b0, mk(26, 35, 1, 1, 1, 127, 31));
        step(1'b0, mk(27, 35, 1, 1, 1, 127, 31));
        step(1'b0, mk(18, 35, 0, 1, 1, 127, 31));
        step(1'b0, mk(700, 500, 0, 0, 1, 127, 31));

        // Cursor at (5,2) across five vsync falling edges.
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 6; i++)
                step(1'b0, mk(40 + int'($urandom_range(0, 7)), 32 + int'($urandom_range(0, 15)),
                              1, 1, 1, 5, 2));
            step(1'b0, mk(0, 0, 0, 1, 0, 5, 2));
            step(1'b0, mk(0, 0, 0, 1, 0, 5, 2));
        end

        // Out-of-range cursor column never shows.
        for (int i = 0; i < 8; i++)
            step(1'b0, mk(40 + i, 32 + 2 * i, 1, 1, 1, 90, 2));

        // Every glyph line of the cursor cell.
        for (int y = 32; y < 48; y++)
            step(1'b0, mk(42, y, 1, 1, 1, 5, 2));

        // Mid-frame reset.
        step(1'b1, mk(100, 100, 1, 0, 0, 5, 2));

        vs_lvl = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            s.x    = 10'($urandom_range(0, 799));
            s.y    = 10'($urandom_range(0, 1023));
            s.disp = (s.x < 10'd640 && s.y[8:0] < 9'd480) && ($urandom_range(0, 7) != 0);
            s.hs   = ($urandom_range(0, 7) != 0);
            vs_lvl = ($urandom_range(0, 15) == 0) ? ~vs_lvl : vs_lvl;
            s.vs   = vs_lvl;
            if ($urandom_range(0, 1) == 1) begin
                s.cc = s.x[9:3];
                s.cr = s.y[8:4];
            end else begin
                s.cc = 7'($urandom_range(0, 127));
                s.cr = 5'($urandom_range(0, 31));
            end
            step(($urandom_range(0, 299) == 0), s);
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
